// File: rtl/loader_pkg.sv
// Shared definitions for the byte-stream instruction memory loader.
package loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CHK,
        DONE,
        ERR
    } loaderState_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         BYTES_PER_WORD    = 2;
    localparam int         BYTE_W            = 8;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit XOR accumulator over the payload bytes of a frame.
module loader_checksum (
    input  logic       CLK,
    input  logic       RST,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] dataByte,
    output logic [7:0] sum
);

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            sum <= '0;
        end else if (enable) begin
            sum <= sum ^ dataByte;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Receives a framed program image byte by byte, writes it into instruction memory
// and releases the processor from reset only after the checksum verifies.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 12,
    parameter int         DATA_W    = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int         COUNT_W   = BYTES_PER_WORD * BYTE_W;
    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

    loaderState_t state;
    loaderState_t nextState;

    logic               xfer;
    logic [BYTE_W-1:0]  countHi;
    logic [COUNT_W-1:0] wordCount;
    logic [COUNT_W-1:0] countFull;
    logic               countBad;
    logic [ADDR_W:0]    wordIdx;
    logic               lastWord;
    logic [BYTE_W-1:0]  hiByte;
    logic [BYTE_W-1:0]  chkSum;
    logic               chkClear;
    logic               chkEnable;

    assign xfer      = rx_valid & rx_ready;
    assign countFull = {countHi, rx_data};
    assign countBad  = (countFull == '0) || (33'(countFull) > MAX_WORDS);
    // The index is one bit wider than the address so a full-memory image ends cleanly.
    assign lastWord  = (33'(wordIdx) + 33'd1) == 33'(wordCount);

    assign chkClear  = xfer && (state == CNT_LO);
    assign chkEnable = xfer && ((state == DATA_HI) || (state == DATA_LO));

    loader_checksum uChecksum (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (chkClear),
        .enable   (chkEnable),
        .dataByte (rx_data),
        .sum      (chkSum)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (xfer && (rx_data == SYNC_BYTE)) nextState = CNT_HI;
            CNT_HI:  if (xfer) nextState = CNT_LO;
            CNT_LO:  if (xfer) nextState = countBad ? ERR : DATA_HI;
            DATA_HI: if (xfer) nextState = DATA_LO;
            DATA_LO: if (xfer) nextState = WRITE;
            WRITE:   nextState = lastWord ? CHK : DATA_HI;
            CHK:     if (xfer) nextState = (rx_data == chkSum) ? DONE : ERR;
            DONE,
            ERR:     if (xfer && (rx_data == SYNC_BYTE)) nextState = CNT_HI;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        rx_ready = !RST && (state != WRITE);
        busy     = (state != IDLE) && (state != DONE) && (state != ERR);
        cpu_rst  = (state != DONE);
        done     = (state == DONE);
        err      = (state == ERR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            countHi   <= '0;
            wordCount <= '0;
            wordIdx   <= '0;
            hiByte    <= '0;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_wren  <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            if (xfer) begin
                case (state)
                    CNT_HI:  countHi <= rx_data;
                    CNT_LO: begin
                        wordCount <= countFull;
                        wordIdx   <= '0;
                    end
                    DATA_HI: hiByte <= rx_data;
                    DATA_LO: begin
                        mem_data <= DATA_W'({hiByte, rx_data});
                        mem_addr <= wordIdx[ADDR_W-1:0];
                        mem_wren <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (state == WRITE) begin
                wordIdx <= wordIdx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: directed frames push expected writes,
// a negedge monitor pops and compares every mem_wren pulse.
module tb_instr_mem_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    int   testsRun    = 0;
    int   testsFailed = 0;
    int   wrenPulses  = 0;
    int   gapCycles   = 0;
    int   wrenBase;
    logic prevWren    = 1'b0;
    logic [7:0] chkAcc;
    wr_t  expQ[$];
    wr_t  monEntry;

    instr_mem_loader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wren (mem_wren),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every write pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (mem_wren === 1'b1) begin
            wrenPulses++;
            checkOutput("wren single cycle", 32'(prevWren), 32'd0);
            checkOutput("rx_ready low in WRITE", 32'(rx_ready), 32'd0);
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_data);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("write addr", 32'(mem_addr), 32'(monEntry.addr));
                checkOutput("write data", 32'(mem_data), 32'(monEntry.data));
            end
        end
        prevWren = mem_wren;
    end

    task automatic applyStimulus(input logic [7:0] b);
        int waitCycles;
        repeat (gapCycles) begin
            @(posedge CLK);
            #1;
        end
        rx_valid   = 1'b1;
        rx_data    = b;
        waitCycles = 0;
        @(negedge CLK);
        while (rx_ready !== 1'b1 && waitCycles < 50) begin
            @(negedge CLK);
            waitCycles++;
        end
        if (rx_ready !== 1'b1) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL byte accept timeout: rx_ready %b, expected 1 within 50 cycles", rx_ready);
        end
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        expQ.push_back('{addr: addr, data: data});
        chkAcc = chkAcc ^ data[15:8] ^ data[7:0];
        applyStimulus(data[15:8]);
        applyStimulus(data[7:0]);
    endtask

    task automatic sendFrameA(input logic [7:0] chk);
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        sendWord(12'h000, 16'h1234);
        sendWord(12'h001, 16'hABCD);
        applyStimulus(chk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
        checkOutput({tag, " mem_data"}, 32'(mem_data), 32'h0);
        checkOutput({tag, " mem_wren"}, 32'(mem_wren), 32'h0);
        checkOutput({tag, " cpu_rst"},  32'(cpu_rst),  32'h1);
        checkOutput({tag, " busy"},     32'(busy),     32'h0);
        checkOutput({tag, " done"},     32'(done),     32'h0);
        checkOutput({tag, " err"},      32'(err),      32'h0);
        checkOutput({tag, " rx_ready"}, 32'(rx_ready), 32'h0);
    endtask

    task automatic doReset(input string tag);
        RST      = 1'b1;
        rx_valid = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        checkResetState(tag);
        RST = 1'b0;
        #1;
        checkOutput({tag, " rx_ready after release"}, 32'(rx_ready), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        doReset("reset");

        // Good two-word frame.
        wrenBase = wrenPulses;
        applyStimulus(8'hA5);
        checkOutput("A busy after sync", 32'(busy), 32'h1);
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        sendWord(12'h000, 16'h1234);
        sendWord(12'h001, 16'hABCD);
        checkOutput("A cpu_rst before chk", 32'(cpu_rst), 32'h1);
        applyStimulus(8'h40);
        checkOutput("A done", 32'(done), 32'h1);
        checkOutput("A err", 32'(err), 32'h0);
        checkOutput("A cpu_rst", 32'(cpu_rst), 32'h0);
        checkOutput("A busy", 32'(busy), 32'h0);
        checkOutput("A wren pulses", 32'(wrenPulses - wrenBase), 32'd2);

        // Restart from DONE with a bad checksum.
        wrenBase = wrenPulses;
        applyStimulus(8'hA5);
        checkOutput("restart cpu_rst", 32'(cpu_rst), 32'h1);
        checkOutput("restart done cleared", 32'(done), 32'h0);
        applyStimulus(8'h00);
        applyStimulus(8'h02);
        sendWord(12'h000, 16'h1234);
        sendWord(12'h001, 16'hABCD);
        applyStimulus(8'h41);
        checkOutput("badchk err", 32'(err), 32'h1);
        checkOutput("badchk done", 32'(done), 32'h0);
        checkOutput("badchk cpu_rst", 32'(cpu_rst), 32'h1);
        checkOutput("badchk wren pulses", 32'(wrenPulses - wrenBase), 32'd2);

        // Illegal word counts: zero and one past memory size.
        wrenBase = wrenPulses;
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        checkOutput("count0 err", 32'(err), 32'h1);
        checkOutput("count0 busy", 32'(busy), 32'h0);
        applyStimulus(8'hA5);
        applyStimulus(8'h10);
        checkOutput("count4097 busy in CNT_LO", 32'(busy), 32'h1);
        applyStimulus(8'h01);
        checkOutput("count4097 err", 32'(err), 32'h1);
        checkOutput("count4097 done", 32'(done), 32'h0);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("bad counts no writes", 32'(wrenPulses - wrenBase), 32'd0);

        // Leading noise and idle gaps between bytes.
        doReset("reset2");
        gapCycles = 2;
        wrenBase  = wrenPulses;
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h3C);
        checkOutput("noise busy", 32'(busy), 32'h0);
        sendFrameA(8'h40);
        checkOutput("gap done", 32'(done), 32'h1);
        checkOutput("gap cpu_rst", 32'(cpu_rst), 32'h0);
        checkOutput("gap wren pulses", 32'(wrenPulses - wrenBase), 32'd2);
        gapCycles = 0;

        // Reset mid-frame after the first of three words.
        wrenBase = wrenPulses;
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'h03);
        sendWord(12'h000, 16'h1122);
        doReset("midreset");
        repeat (5) @(posedge CLK);
        #1;
        checkOutput("midreset wren pulses", 32'(wrenPulses - wrenBase), 32'd1);
        sendFrameA(8'h40);
        checkOutput("after midreset done", 32'(done), 32'h1);

        // Full-memory image from DONE.
        wrenBase = wrenPulses;
        chkAcc   = 8'h00;
        applyStimulus(8'hA5);
        checkOutput("full cpu_rst on restart", 32'(cpu_rst), 32'h1);
        checkOutput("full busy", 32'(busy), 32'h1);
        applyStimulus(8'h10);
        applyStimulus(8'h00);
        for (int i = 0; i < 4096; i++) begin
            sendWord(ADDR_W'(i), 16'(i * 16'h9E37 + 16'h1357));
        end
        applyStimulus(chkAcc);
        checkOutput("full done", 32'(done), 32'h1);
        checkOutput("full err", 32'(err), 32'h0);
        checkOutput("full cpu_rst", 32'(cpu_rst), 32'h0);
        checkOutput("full last addr", 32'(mem_addr), 32'hFFF);
        checkOutput("full wren pulses", 32'(wrenPulses - wrenBase), 32'd4096);

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Byte-stream program loader: the writer side of the instruction memory that the processor fetches from.
- Receives a framed program image over a valid/ready byte interface.
- Assembles 16-bit instruction words and writes them sequentially into instruction memory from address 0.
- Holds the processor in reset until a complete, checksum-verified image has been written, then releases it.

Parameters:
ADDR_W, 12, instruction memory address width (word addressed)
DATA_W, 16, instruction width; fixed two bytes per word
SYNC_BYTE, 8'hA5, frame start marker

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
rx_valid  in  1  byte available on rx_data
rx_data  in  8  incoming byte
rx_ready  out  1  loader accepts byte this cycle; transfer = rx_valid & rx_ready
mem_addr  out  ADDR_W  instruction memory write address
mem_data  out  DATA_W  instruction memory write data
mem_wren  out  1  one-cycle write strobe
cpu_rst  out  1  processor reset (high = held in reset)
busy  out  1  frame in progress
done  out  1  last frame loaded and verified
err  out  1  last frame rejected

Behaviour:
- Frame format, in order:
  - SYNC_BYTE
  - CNT_HI, CNT_LO: word count N, big-endian
  - N words, each hi byte then lo byte
  - CHK: XOR of all 2N payload bytes
- Reset values: state IDLE, mem_addr 0, mem_data 0, mem_wren 0, cpu_rst 1, busy 0, done 0, err 0, word counter 0, checksum accumulator 0. RST mid-frame aborts with no further writes.
- rx_ready = 1 in every state except WRITE; forced 0 while RST is high.
- busy = 1 in all states except IDLE, DONE and ERR.
- cpu_rst = 1 everywhere except DONE.
- mem_addr, mem_data, mem_wren are registered.
- States and transitions (a transfer advances the state; no transfer holds the state):
  - IDLE: byte == SYNC_BYTE -> CNT_HI; any other byte is discarded.
  - CNT_HI: latch count[15:8] -> CNT_LO.
  - CNT_LO: latch count[7:0]; clear accumulator and word index.
    - N == 0 or N > 2^ADDR_W -> ERR.
    - otherwise -> DATA_HI.
  - DATA_HI: hold byte, XOR into accumulator -> DATA_LO.
  - DATA_LO: XOR into accumulator; register mem_data = {hi, lo}, mem_addr = word index; mem_wren = 1 next cycle -> WRITE.
  - WRITE (exactly 1 cycle, mem_wren high, rx_ready low): increment word index.
    - index+1 == N -> CHK.
    - otherwise -> DATA_HI.
  - CHK: byte == accumulator -> DONE (done = 1, err = 0); mismatch -> ERR (err = 1, done = 0).
  - DONE / ERR: byte == SYNC_BYTE restarts -> CNT_HI; done, err cleared; cpu_rst reasserted in the same cycle. Other bytes are discarded.
- Word index is ADDR_W+1 bits wide so that N = 2^ADDR_W terminates without wrap. The last write goes to address 2^ADDR_W-1; mem_addr never wraps.
- The write-to-memory latency is one cycle after the DATA_LO byte is accepted.
- Each word's write completes before the next byte is accepted.
- Memory contents written before an ERR are not rolled back. The processor stays in reset, so they are never executed.

Decomposition:
- Shared package (loader_pkg): state enum (IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR), SYNC_BYTE default, bytes-per-word constant 2.
- One natural sub-module: loader_checksum, an 8-bit XOR accumulator with clear and enable. FSM and datapath stay in the top module.

Test Plan:
- Reset, then frame A5 00 02 12 34 AB CD 40 (0x12^0x34^0xAB^0xCD = 0x40) -> writes {0x000: 0x1234, 0x001: 0xABCD}; mem_wren high exactly 2 cycles; done = 1, cpu_rst = 0 after the CHK byte; rx_ready low during each WRITE cycle.
- Same frame with CHK = 0x41 -> both writes occur; err = 1, done = 0, cpu_rst stays 1.
- Count 00 00, and separately 10 01 (4097) -> ERR right after CNT_LO; no mem_wren pulse.
- Bytes 00 FF 3C before A5, plus rx_valid gaps between frame bytes -> noise discarded, gaps add no extra writes, load completes identically.
- RST pulsed after the first data word of a 3-word frame -> outputs return to reset values, no further writes; a fresh valid frame then loads correctly.
- From DONE, send a new A5 frame -> cpu_rst reasserts on the A5 cycle; full 4096-word load ends at mem_addr 0xFFF without wrap, then done = 1.
